// File: rtl/fmap_pkg.sv
// Shared constants and FSM state type for the feature-map read sequencer.
package fmap_pkg;

   localparam int DATA_W       = 16;
   localparam int LANES        = 16;
   localparam int FMAP55_PLANE = 3025;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ISSUE  = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ISSUE  = ST_ISSUE,
      DRAIN  = ST_DRAIN,
      FINISH = ST_FINISH
   } state_t;

endpackage

// File: rtl/fmap_read_sequencer_if.sv
// Memory read port plus output pixel-vector stream of the read sequencer.
interface fmap_read_sequencer_if #(
   parameter int ADDR_W = 32,
   parameter int VEC_W  = 256
);
   import fmap_pkg::*;

   logic              mem_rden;
   logic [ADDR_W-1:0] mem_addr;
   logic [VEC_W-1:0]  mem_data;
   logic [VEC_W-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output mem_rden, mem_addr, out_data, out_valid, out_last,
      input  mem_data, out_ready
   );

   modport slave (
      input  mem_rden, mem_addr, out_data, out_valid, out_last,
      output mem_data, out_ready
   );

endinterface

// File: rtl/fmap_read_sequencer_skid_fifo2.sv
// Two-entry FIFO holding returned read words (plus last tag) against backpressure.
module skid_fifo2 #(
   parameter int WIDTH = 257
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_r [2];
   logic             wr_ptr_r;
   logic             rd_ptr_r;
   logic [1:0]       count_r;

   // Storage, pointers and occupancy; the caller guarantees no push when full.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_r[0] <= {WIDTH{1'b0}};
         mem_r[1] <= {WIDTH{1'b0}};
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fmap_read_sequencer.sv
// Walks one stored feature map (group, row, column order) and streams the
// returned 16-lane words out through a credit-limited two-entry skid FIFO.
module fmap_read_sequencer #(
   parameter int DATA_W = 16,
   parameter int LANES  = 16,
   parameter int ADDR_W = 32,
   parameter int DIM_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [DIM_W-1:0]     fm_height,
   input  logic [DIM_W-1:0]     fm_width,
   input  logic [DIM_W-1:0]     ch_groups,
   input  logic [ADDR_W-1:0]    plane_size,
   fmap_read_sequencer_if.master bus,
   output logic                 busy,
   output logic                 done
);
   import fmap_pkg::*;

   localparam int VEC_W = LANES * DATA_W;

   state_t            state_r, state_nx;
   logic [DIM_W-1:0]  h_r, w_r, gcfg_r, g_r, r_r, c_r;
   logic [ADDR_W-1:0] stride_r, grp_base_r, row_base_r, addr_r;
   logic              inflight_r, last_pend_r;
   logic [1:0]        fifo_count_s;
   logic [VEC_W:0]    fifo_head_s;
   logic [2:0]        used_s;
   logic              pop_s, rden_s, is_last_s, zero_cfg_s, drained_s;
   logic              c_end_s, r_end_s, g_end_s;

   assign c_end_s    = (c_r == w_r - DIM_W'(1));
   assign r_end_s    = (r_r == h_r - DIM_W'(1));
   assign g_end_s    = (g_r == gcfg_r - DIM_W'(1));
   assign is_last_s  = c_end_s & r_end_s & g_end_s;
   assign zero_cfg_s = (fm_height == DIM_W'(0)) | (fm_width == DIM_W'(0)) | (ch_groups == DIM_W'(0));
   assign pop_s      = (fifo_count_s != 2'd0) & bus.out_ready;

   // Credit uses the post-pop occupancy so a draining consumer sees one read per cycle.
   always_comb begin
      used_s    = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
      rden_s    = (state_r == ISSUE) && (used_s < 3'd2);
      drained_s = !inflight_r && ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && pop_s));
   end

   // Next-state logic.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx = zero_cfg_s ? FINISH : ISSUE;
            end else begin
               state_nx = IDLE;
            end
         end
         ISSUE: begin
            if (rden_s && is_last_s) begin
               state_nx = DRAIN;
            end else begin
               state_nx = ISSUE;
            end
         end
         DRAIN: begin
            if (drained_s) begin
               state_nx = FINISH;
            end else begin
               state_nx = DRAIN;
            end
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Config latch and incremental scan address (running group/row bases).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         h_r <= '0; w_r <= '0; gcfg_r <= '0;
         g_r <= '0; r_r <= '0; c_r <= '0;
         stride_r <= '0; grp_base_r <= '0; row_base_r <= '0; addr_r <= '0;
      end else if ((state_r == IDLE) && start) begin
         h_r        <= fm_height;
         w_r        <= fm_width;
         gcfg_r     <= ch_groups;
         g_r        <= '0;
         r_r        <= '0;
         c_r        <= '0;
         stride_r   <= plane_size << $clog2(LANES);
         grp_base_r <= base_addr;
         row_base_r <= base_addr;
         addr_r     <= base_addr;
      end else if (rden_s && !is_last_s) begin
         if (!c_end_s) begin
            c_r    <= c_r + DIM_W'(1);
            addr_r <= addr_r + ADDR_W'(1);
         end else if (!r_end_s) begin
            c_r        <= '0;
            r_r        <= r_r + DIM_W'(1);
            row_base_r <= row_base_r + ADDR_W'(w_r);
            addr_r     <= row_base_r + ADDR_W'(w_r);
         end else begin
            c_r        <= '0;
            r_r        <= '0;
            g_r        <= g_r + DIM_W'(1);
            grp_base_r <= grp_base_r + stride_r;
            row_base_r <= grp_base_r + stride_r;
            addr_r     <= grp_base_r + stride_r;
         end
      end
   end

   // Read-return tracking: data and its last tag arrive one cycle after rden.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inflight_r  <= 1'b0;
         last_pend_r <= 1'b0;
      end else begin
         inflight_r  <= rden_s;
         last_pend_r <= rden_s & is_last_s;
      end
   end

   skid_fifo2 #(.WIDTH(VEC_W + 1)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_r),
      .push_data ({last_pend_r, bus.mem_data}),
      .pop       (pop_s),
      .count     (fifo_count_s),
      .head      (fifo_head_s)
   );

   assign bus.mem_rden  = rden_s;
   assign bus.mem_addr  = addr_r;
   assign bus.out_valid = (fifo_count_s != 2'd0);
   assign bus.out_data  = fifo_head_s[VEC_W-1:0];
   assign bus.out_last  = (fifo_count_s != 2'd0) & fifo_head_s[VEC_W];
   assign busy          = (state_r != IDLE);
   assign done          = (state_r == FINISH);

endmodule

// File: doc/fmap_read_sequencer.md
Name: fmap_read_sequencer

Overview:
- Downstream consumer of the ping-pong feature-map memory. Walks one stored feature map and drives the memory read port (rden, address2), which returns 16 lanes x 16 bit one cycle after rden.
- Repackages the returned words into a valid/ready stream of 16-channel pixel vectors for the next fire/conv stage.
- Handles output backpressure with a credit-limited 2-entry skid FIFO, so no returned read data is ever dropped.

Parameters:
- DATA_W, 16, bits per channel lane
- LANES, 16, channels per memory read word
- ADDR_W, 32, memory address width
- DIM_W, 8, width of the height/width/group counters

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches the configuration and begins a scan
- base_addr  in  ADDR_W  address of pixel (0,0) of channel group 0
- fm_height  in  DIM_W  rows
- fm_width  in  DIM_W  columns
- ch_groups  in  DIM_W  number of 16-channel groups
- plane_size  in  ADDR_W  words per channel plane (3025 for 55x55)
- mem_rden  out  1  memory read enable
- mem_addr  out  ADDR_W  memory address2
- mem_data  in  LANES*DATA_W  memory dataout, valid one cycle after mem_rden
- out_data  out  LANES*DATA_W  pixel vector; lane i is channel g*16+i
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  marks the final vector of the scan
- busy  out  1  high from start until the last vector is accepted
- done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (rst=0, async): state IDLE, all counters 0, FIFO empty. mem_rden=0, mem_addr=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0. Reset mid-scan aborts the scan and discards in-flight data.
- States: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE -> ISSUE on start. Config is latched into registers and counters g/r/c are cleared.
  - If any of fm_height, fm_width or ch_groups is 0: IDLE -> FINISH directly. No reads are issued, done pulses the next cycle and out_valid is never raised.
  - start while busy is ignored.
- Scan order: g outermost, then r, then c innermost.
  - Address = base_addr + g*LANES*plane_size + r*fm_width + c.
  - Address arithmetic is ADDR_W bits, modulo 2^ADDR_W.
  - Compute it incrementally with running row-base and group-base registers (no multipliers in the issue path).
- Issue rule:
  - mem_rden=1 in ISSUE only when fifo_count + inflight < 2. inflight is the one-cycle read-return flag.
  - One cycle after each rden, mem_data is pushed into the FIFO, together with a last tag set on the final address.
  - When the final address issues: ISSUE -> DRAIN.
- Throughput: 1 vector/cycle sustained while out_ready=1.
- Latency: start -> first mem_rden = 1 cycle; first out_valid 2 cycles after that first mem_rden.
- Output:
  - out_valid = FIFO non-empty; out_data/out_last show the FIFO head.
  - Pop on out_valid & out_ready.
  - Once out_valid is high, out_data is held stable until accepted.
- A simultaneous push and pop on a full FIFO is impossible because of the credit rule. A push and pop in the same cycle on a one-entry FIFO keeps the count at 1.
- DRAIN -> FINISH when the FIFO is empty and inflight=0. FINISH asserts done for 1 cycle, then goes to IDLE.
- busy = (state != IDLE).

Decomposition:
- Package fmap_pkg holds:
  - state encoding localparams (IDLE=0, ISSUE=1, DRAIN=2, FINISH=3)
  - LANES, DATA_W
  - FMAP55_PLANE=3025
- Sub-module skid_fifo2: 2-entry, width LANES*DATA_W+1 (data plus last tag), with push/pop/count. The top level owns the counters, address generation, credit logic and FSM.

Test Plan:
1. Config base=0, H=2, W=3, G=1, plane=3025, out_ready=1. Required: mem_addr sequence 0,1,2,3,4,5 on 6 consecutive cycles; 6 vectors out; out_last on the 6th; done 1 cycle after the last handshake.
2. Config G=2, H=W=1, base=100, plane=3025. Required: addresses 100 then 48500 (100 + 16*3025).
3. Backpressure: H=1, W=8, out_ready low for cycles 3..10. Required: at most 2 vectors buffered; no loss, no duplication; mem_rden stalls while fifo_count + inflight = 2; the bench model compares all 8 vectors in order.
4. Random out_ready (50%), H=W=5, G=3. Required: 75 vectors in scan order; out_data stable while out_valid & !out_ready.
5. Zero-size case: W=0. Required: done 1 cycle after start; no mem_rden, no out_valid.
6. Reset mid-scan: assert rst low during DRAIN. Required: all outputs immediately 0. A new start after rst goes high runs the full scan cleanly.
